gpu_ram_write_port: RTL

- Memory-side responder for sprite-engine write requests: collision logic issuing pill-eaten tile clears and similar updates.
- Buffers GPU writes in a small FIFO and merges them with CPU writes onto the single shared video-RAM write port.
- Pauses the CPU when the buffer needs draining.
- Sits between the sprite/collision logic and the tile-RAM write port, beside the CPU bus.

---
 rtl/gpu_ram_pkg.sv | 33 +++
 rtl/gpu_ram_write_port_if.sv | 20 ++
 rtl/gpu_ram_write_port_wr_fifo.sv | 54 +++++
 rtl/gpu_ram_write_port.sv | 113 +++++++++++
 4 files changed

// File: rtl/gpu_ram_pkg.sv
// Shared types and window helpers for the GPU/CPU video-RAM write port.
package gpu_ram_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] DEF_WIN_BASE = 16'h4000;
  localparam logic [ADDR_W-1:0] DEF_WIN_SIZE = 16'h0800;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ram_wr_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } port_state_t;

  // Extra bit keeps base+size from wrapping at the top of the address space.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] size);
    logic [ADDR_W:0] a;
    logic [ADDR_W:0] lo;
    logic [ADDR_W:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = (ADDR_W+1)'(lo + {1'b0, size});
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/gpu_ram_write_port_if.sv
// GPU write-request channel: valid/ready handshake plus flush pulse.
interface gpu_ram_write_port_if;
  import gpu_ram_pkg::*;

  logic              gpu_wr_valid;
  logic              gpu_wr_ready;
  logic [ADDR_W-1:0] gpu_ram_addr;
  logic [DATA_W-1:0] gpu_ram_din;
  logic              gpu_flush;

  modport master (
    output gpu_wr_valid, gpu_ram_addr, gpu_ram_din, gpu_flush,
    input  gpu_wr_ready
  );

  modport slave (
    input  gpu_wr_valid, gpu_ram_addr, gpu_ram_din, gpu_flush,
    output gpu_wr_ready
  );
endinterface

// File: rtl/gpu_ram_write_port_wr_fifo.sv
// Small synchronous FIFO of pending GPU RAM writes; pointers wrap naturally.
module wr_fifo
  import gpu_ram_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  ram_wr_t                    wdata,
  input  logic                       pop,
  output ram_wr_t                    rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ram_wr_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_ram_write_port.sv
// Merges buffered GPU writes with CPU writes onto one registered RAM write port;
// pauses the CPU while the GPU buffer drains.
module gpu_ram_write_port
  import gpu_ram_pkg::*;
#(
  parameter int unsigned       DEPTH        = 4,
  parameter int unsigned       DRAIN_THRESH = 3,
  parameter logic [ADDR_W-1:0] WIN_BASE     = DEF_WIN_BASE,
  parameter logic [ADDR_W-1:0] WIN_SIZE     = DEF_WIN_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  gpu_ram_write_port_if.slave gpu,
  input  logic                cpu_wr_en,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_din,
  output logic                cpu_pause,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  output logic [15:0]         gpu_wr_count,
  output logic                range_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  port_state_t      state;
  ram_wr_t          push_data;
  ram_wr_t          head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             ready;
  logic             accept;
  logic             in_win;
  logic             push;
  logic             pop;

  wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Ready comes only from registered occupancy, never from a same-cycle pop.
  assign ready            = !rst && !fifo_full;
  assign gpu.gpu_wr_ready = ready;

  always_comb begin
    accept     = gpu.gpu_wr_valid && ready;
    in_win     = in_window(gpu.gpu_ram_addr, WIN_BASE, WIN_SIZE);
    push       = accept && in_win;
    pop        = !cpu_wr_en && !fifo_empty;
    push_data  = '{addr: gpu.gpu_ram_addr, data: gpu.gpu_ram_din};
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Port arbitration: CPU always wins; otherwise drain the FIFO head.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_din      <= '0;
      gpu_wr_count <= '0;
      range_err    <= 1'b0;
    end else begin
      if (cpu_wr_en) begin
        ram_we   <= 1'b1;
        ram_addr <= cpu_addr;
        ram_din  <= cpu_din;
      end else if (!fifo_empty) begin
        ram_we       <= 1'b1;
        ram_addr     <= head.addr;
        ram_din      <= head.data;
        gpu_wr_count <= gpu_wr_count + 16'(1);
      end else begin
        ram_we <= 1'b0;
      end
      if (accept && !in_win) range_err <= 1'b1;
    end
  end

  // Drain FSM; cpu_pause tracks the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cpu_pause <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if ((count >= CNT_W'(DRAIN_THRESH)) || (gpu.gpu_flush && (count != '0))) begin
            state     <= DRAIN;
            cpu_pause <= 1'b1;
          end
        end
        DRAIN: begin
          if (count_next == '0) begin
            state     <= IDLE;
            cpu_pause <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
